uart_apb_master: RTL and testbench
==================================

# uart_apb_master

APB initiator that turns single-word load/store requests from the RISC-V core's peripheral port into APB transfers toward the UART APB slave (5-bit register space: 0x00 enable, 0x04 control, 0x08 status, 0x0C data). It issues the standard SETUP then ACCESS sequence, waits on PREADY, returns read data or an error, and optionally aborts hung transfers with a timeout. It sits between the core's load/store unit and the UART slave, as the counterpart on the other end of that APB link.

## Interface

- ADDR_W, 5, APB address width
- DATA_W, 32, APB data width
- TIMEOUT, 255, ACCESS-phase cycles without PREADY before abort (used only with timeout compiled in; minimum 1)

- PCLK  in  1  clock; all logic on the rising edge
- PRESET  in  1  reset, synchronous, active-high
- req_valid  in  1  core request present
- req_ready  out  1  initiator can accept a request
- req_write  in  1  1 = write, 0 = read
- req_addr  in  ADDR_W  byte address
- req_wdata  in  DATA_W  write data
- rsp_valid  out  1  one-cycle response pulse
- rsp_rdata  out  DATA_W  read data; 0 for writes and errors
- rsp_err  out  1  qualifies rsp_valid: misaligned address or timeout
- PSEL, PENABLE, PWRITE  out  1 each  APB control
- PADDR  out  ADDR_W  APB address
- PWDATA  out  DATA_W  APB write data
- PRDATA  in  DATA_W  APB read data
- PREADY  in  1  slave ready

## Operation

- FSM has three states: IDLE, SETUP, ACCESS. All outputs are registered.
- IDLE:
  - req_ready=1; PSEL=0, PENABLE=0.
  - A request is accepted on an edge where req_valid && req_ready. req_write, req_addr and req_wdata are latched into PWRITE, PADDR and PWDATA.
- Alignment check: an accepted request with req_addr[1:0]!=0 issues no APB transfer. The FSM stays in IDLE and drives rsp_valid=1, rsp_err=1, rsp_rdata=0 in the next cycle.
- SETUP: PSEL=1, PENABLE=0, req_ready=0. Unconditionally goes to ACCESS.
- ACCESS: PSEL=1, PENABLE=1. Stays in ACCESS while PREADY=0.
  - On an edge with PREADY=1, go to IDLE.
  - On that edge, rsp_rdata captures PRDATA for reads or 0 for writes.
  - In the following cycle, rsp_valid=1 and rsp_err=0.
- PADDR, PWDATA and PWRITE are stable from SETUP through the end of ACCESS. They hold their last value in IDLE.
- rsp_valid is exactly one cycle wide. rsp_rdata and rsp_err hold until the next response.
- Reset values: req_ready=1 (after reset), rsp_valid=0, rsp_err=0, rsp_rdata=0, PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0. State is IDLE and the timeout counter is 0.
- Reset mid-transfer: PSEL and PENABLE are 0 in the cycle after the reset edge, and no response is issued for the aborted transfer.

## Timing

- Request accepted at edge N:
  - cycle N+1 is SETUP;
  - cycle N+2 is ACCESS;
  - if PREADY=1 in cycle N+2, rsp_valid=1 in cycle N+3, with req_ready=1 in the same cycle.
- Each PREADY=0 cycle in ACCESS adds one cycle of latency.
- Back-to-back throughput is one transfer per 3 cycles minimum. A new request may be accepted in the cycle where rsp_valid is high.
- Misaligned request accepted at edge N: rsp_valid/rsp_err are high in cycle N+1, and req_ready stays 1.
- Inputs req_* are sampled only at acceptance. Changes to them at other times have no effect.

## Configuration

- Macro: UART_APB_MASTER_TIMEOUT_EN.
- Defined:
  - An 8-bit counter clears on entering ACCESS and increments on each ACCESS cycle with PREADY=0.
  - When the count reaches TIMEOUT with PREADY still 0, the FSM goes to IDLE. PSEL and PENABLE drop the next cycle, and rsp_valid=1, rsp_err=1, rsp_rdata=0 are driven in that same cycle.
  - PREADY=1 on the same edge the count reaches TIMEOUT counts as a normal completion, with rsp_err=0.
- Undefined: there is no counter. ACCESS waits indefinitely for PREADY, and rsp_err comes only from the alignment check.

## Test plan

- Write: req 0x00/write/0x00000003 with PREADY tied 1 -> SETUP then ACCESS with PADDR=0x00, PWDATA=0x3, PWRITE=1; rsp_valid at N+3, rsp_err=0, rsp_rdata=0.
- Wait-state read: read 0x08 with PREADY held low 3 ACCESS cycles, PRDATA=0x000000A5 -> ACCESS lasts 4 cycles, PADDR stable throughout, rsp_rdata=0x000000A5 at N+6.
- Misaligned: read 0x05 -> PSEL never asserts; rsp_valid=1, rsp_err=1, rsp_rdata=0 at N+1.
- Timeout (macro defined, TIMEOUT=8): PREADY stuck 0 -> abort after 8 wait cycles with rsp_err=1 and PSEL=0 the following cycle. Repeat with macro undefined -> still in ACCESS after 100 cycles.
- Reset in ACCESS: assert PRESET one cycle during ACCESS -> PSEL=0, PENABLE=0 and req_ready=1 after the reset edge, no rsp_valid; the next write to 0x0C with 0x41 completes normally.
- Back-to-back: write 0x04=0x5, then read 0x0C with req_valid held high -> second accept in the first transfer's rsp cycle; 3-cycle spacing; both responses correct.

Source files
------------

// File: rtl/uart_apb_master.sv
// rtl/uart_apb_master.sv - APB initiator bridging core load/store requests to the UART APB slave
// Optional ACCESS-phase timeout abort: define UART_APB_MASTER_TIMEOUT_EN.
module uart_apb_master #(
    parameter int ADDR_W  = 5,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              PSEL,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [ADDR_W-1:0] PADDR,
    output logic [DATA_W-1:0] PWDATA,
    input  logic [DATA_W-1:0] PRDATA,
    input  logic              PREADY
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETUP  = 2'd1;
    localparam logic [1:0] ST_ACCESS = 2'd2;

    if (TIMEOUT < 1 || TIMEOUT > 255 || ADDR_W < 2) begin : g_bad_params
        $error("uart_apb_master: TIMEOUT must be 1..255 and ADDR_W at least 2");
    end

    logic [1:0] state;
    logic       timed_out;

`ifdef UART_APB_MASTER_TIMEOUT_EN
    // Abort on the edge that would bring the wait count up to TIMEOUT.
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);
    logic [7:0] wait_cnt;

    assign timed_out = !PREADY && (wait_cnt == WAIT_LAST);

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            wait_cnt <= 8'd0;
        end else if (state == ST_SETUP) begin
            wait_cnt <= 8'd0;
        end else if (state == ST_ACCESS && !PREADY) begin
            wait_cnt <= wait_cnt + 8'd1;
        end
    end
`else
    assign timed_out = 1'b0;
`endif

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state     <= ST_IDLE;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
            PSEL      <= 1'b0;
            PENABLE   <= 1'b0;
            PWRITE    <= 1'b0;
            PADDR     <= '0;
            PWDATA    <= '0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (req_valid && req_ready) begin
                        PWRITE <= req_write;
                        PADDR  <= req_addr;
                        PWDATA <= req_wdata;
                        // Misaligned word access never reaches the bus.
                        if (req_addr[1:0] != 2'b00) begin
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            rsp_rdata <= '0;
                        end else begin
                            state     <= ST_SETUP;
                            PSEL      <= 1'b1;
                            req_ready <= 1'b0;
                        end
                    end
                end
                ST_SETUP: begin
                    state   <= ST_ACCESS;
                    PENABLE <= 1'b1;
                end
                ST_ACCESS: begin
                    if (PREADY) begin
                        state     <= ST_IDLE;
                        PSEL      <= 1'b0;
                        PENABLE   <= 1'b0;
                        req_ready <= 1'b1;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b0;
                        rsp_rdata <= PWRITE ? '0 : PRDATA;
                    end else if (timed_out) begin
                        state     <= ST_IDLE;
                        PSEL      <= 1'b0;
                        PENABLE   <= 1'b0;
                        req_ready <= 1'b1;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                        rsp_rdata <= '0;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    PSEL      <= 1'b0;
                    PENABLE   <= 1'b0;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_apb_master.sv
// tb/tb_uart_apb_master.sv - cycle-checked bench for uart_apb_master against a transaction-level model
module tb_uart_apb_master;

    localparam int AW = 5;
    localparam int DW = 32;
    localparam int TO = 8;

    logic          PCLK = 1'b0;
    logic          PRESET;
    logic          req_valid, req_ready, req_write;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          rsp_valid, rsp_err;
    logic [DW-1:0] rsp_rdata;
    logic          PSEL, PENABLE, PWRITE;
    logic [AW-1:0] PADDR;
    logic [DW-1:0] PWDATA, PRDATA;
    logic          PREADY;

    int checks = 0;
    int errors = 0;

    uart_apb_master #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .PCLK(PCLK), .PRESET(PRESET),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY)
    );

    always #5 PCLK = ~PCLK;

    function automatic void chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endfunction

    // Transaction-level model: tracks an in-flight transfer by its age in cycles.
    bit            model_ok = 0;
    bit            m_busy = 0;
    int            m_age = 0;
    int            m_waits = 0;
    logic          e_req_ready, e_rsp_valid, e_rsp_err, e_psel, e_penable, e_pwrite;
    logic [DW-1:0] e_rsp_rdata, e_pwdata;
    logic [AW-1:0] e_paddr;

    always @(posedge PCLK) begin
        if (PRESET) begin
            m_busy = 0; m_age = 0; m_waits = 0;
            e_rsp_valid = 0; e_rsp_err = 0; e_rsp_rdata = 0;
            e_pwrite = 0; e_paddr = 0; e_pwdata = 0;
            model_ok = 1;
        end else begin
            e_rsp_valid = 0;
            if (!m_busy) begin
                if (req_valid) begin
                    e_pwrite = req_write; e_paddr = req_addr; e_pwdata = req_wdata;
                    if (int'(req_addr) % 4 != 0) begin
                        e_rsp_valid = 1; e_rsp_err = 1; e_rsp_rdata = 0;
                    end else begin
                        m_busy = 1; m_age = 0; m_waits = 0;
                    end
                end
            end else begin
                m_age++;
                if (m_age >= 2) begin
                    if (PREADY) begin
                        m_busy = 0;
                        e_rsp_valid = 1; e_rsp_err = 0;
                        e_rsp_rdata = e_pwrite ? '0 : PRDATA;
                    end else begin
                        m_waits++;
`ifdef UART_APB_MASTER_TIMEOUT_EN
                        if (m_waits == TO) begin
                            m_busy = 0;
                            e_rsp_valid = 1; e_rsp_err = 1; e_rsp_rdata = 0;
                        end
`endif
                    end
                end
            end
        end
        e_psel      = m_busy;
        e_penable   = m_busy && m_age >= 1;
        e_req_ready = !m_busy;
    end

    always @(negedge PCLK) begin
        if (model_ok) begin
            chk("m_req_ready", req_ready, e_req_ready);
            chk("m_rsp_valid", rsp_valid, e_rsp_valid);
            chk("m_rsp_err",   rsp_err,   e_rsp_err);
            chk("m_rsp_rdata", rsp_rdata, e_rsp_rdata);
            chk("m_psel",      PSEL,      e_psel);
            chk("m_penable",   PENABLE,   e_penable);
            chk("m_pwrite",    PWRITE,    e_pwrite);
            chk("m_paddr",     DW'(PADDR), DW'(e_paddr));
            chk("m_pwdata",    PWDATA,    e_pwdata);
        end
    end

    task automatic step();
        @(negedge PCLK);
    endtask

    task automatic request(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = d;
    endtask

    initial begin
        PRESET = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
        PRDATA = '0; PREADY = 1'b1;
        step(); step();
        chk("rst_req_ready", req_ready, 1);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_psel", PSEL, 0);
        chk("rst_paddr", DW'(PADDR), 0);
        PRESET = 1'b0;
        step();

        // Write 0x00 = 3, zero wait states
        request(1'b1, 5'h00, 32'h3);
        step(); req_valid = 1'b0;
        chk("wr_setup_psel", PSEL, 1);
        chk("wr_setup_penable", PENABLE, 0);
        chk("wr_setup_pwdata", PWDATA, 32'h3);
        chk("wr_setup_ready", req_ready, 0);
        step();
        chk("wr_access_penable", PENABLE, 1);
        step();
        chk("wr_rsp_valid", rsp_valid, 1);
        chk("wr_rsp_rdata", rsp_rdata, 0);
        chk("wr_rsp_ready", req_ready, 1);
        step();
        chk("wr_rsp_pulse", rsp_valid, 0);

        // Read 0x08 with three wait states
        PREADY = 1'b0; PRDATA = 32'h000000A5;
        request(1'b0, 5'h08, 32'hDEAD);
        step(); req_valid = 1'b0; req_addr = 5'h1C;
        step();
        for (int k = 0; k < 3; k++) begin
            chk("ws_penable", PENABLE, 1);
            chk("ws_paddr", DW'(PADDR), 32'h8);
            step();
        end
        PREADY = 1'b1;
        chk("ws_last_penable", PENABLE, 1);
        step();
        chk("ws_rsp_valid", rsp_valid, 1);
        chk("ws_rsp_rdata", rsp_rdata, 32'hA5);
        PRDATA = '0;
        step();

        // Misaligned read 0x05
        request(1'b0, 5'h05, 32'h0);
        step(); req_valid = 1'b0;
        chk("mis_rsp_valid", rsp_valid, 1);
        chk("mis_rsp_err", rsp_err, 1);
        chk("mis_rsp_rdata", rsp_rdata, 0);
        chk("mis_psel", PSEL, 0);
        chk("mis_ready", req_ready, 1);
        step();

        // Stuck slave
        PREADY = 1'b0;
        request(1'b0, 5'h0C, 32'h0);
        step(); req_valid = 1'b0;
`ifdef UART_APB_MASTER_TIMEOUT_EN
        repeat (8) step();
        chk("to_last_wait_psel", PSEL, 1);
        step();
        chk("to_psel", PSEL, 0);
        chk("to_rsp_valid", rsp_valid, 1);
        chk("to_rsp_err", rsp_err, 1);
        step();
        request(1'b0, 5'h0C, 32'h0);
        step(); req_valid = 1'b0;
        step(); step();
`else
        repeat (100) step();
        chk("hang_psel", PSEL, 1);
        chk("hang_penable", PENABLE, 1);
        chk("hang_rsp_valid", rsp_valid, 0);
`endif

        // Reset during ACCESS
        chk("pre_rst_penable", PENABLE, 1);
        PRESET = 1'b1;
        step(); PRESET = 1'b0; PREADY = 1'b1;
        chk("rst_mid_psel", PSEL, 0);
        chk("rst_mid_penable", PENABLE, 0);
        chk("rst_mid_ready", req_ready, 1);
        chk("rst_mid_rsp", rsp_valid, 0);
        step();
        chk("rst_mid_rsp2", rsp_valid, 0);
        request(1'b1, 5'h0C, 32'h41);
        step(); req_valid = 1'b0;
        step(); step();
        chk("post_rst_rsp", rsp_valid, 1);
        chk("post_rst_err", rsp_err, 0);
        chk("post_rst_pwdata", PWDATA, 32'h41);
        step();

        // Back-to-back: write 0x04=5, then read 0x0C with req_valid held
        PRDATA = 32'h12345678;
        request(1'b1, 5'h04, 32'h5);
        step();
        request(1'b0, 5'h0C, 32'h0);
        chk("b2b_busy_ready", req_ready, 0);
        step(); step();
        chk("b2b_rsp1", rsp_valid, 1);
        chk("b2b_rsp1_rdata", rsp_rdata, 0);
        chk("b2b_rsp1_ready", req_ready, 1);
        step(); req_valid = 1'b0;
        chk("b2b_setup2_psel", PSEL, 1);
        chk("b2b_setup2_paddr", DW'(PADDR), 32'hC);
        chk("b2b_setup2_pwrite", PWRITE, 0);
        step(); step();
        chk("b2b_rsp2", rsp_valid, 1);
        chk("b2b_rsp2_rdata", rsp_rdata, 32'h12345678);
        step(); step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
